// File: rtl/ascon_pack.sv
// Shared ASCON definitions: round-controller FSM states, round index
// bounds and the round-constant function used by the constant-addition layer.
package ascon_pack;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_round_fsm;

    localparam logic [3:0] ROUND_FIRST_A = 4'd0;
    localparam logic [3:0] ROUND_FIRST_B = 4'd6;
    localparam logic [3:0] ROUND_LAST    = 4'd11;

    // Round constant for index i: upper nibble counts down from 15, lower up from 0.
    function automatic logic [7:0] round_const(input logic [3:0] i);
        return {4'd15 - i, i};
    endfunction

endpackage

// File: rtl/round_counter.sv
// 4-bit loadable round counter with increment enable and a last-round flag.
// The flag is a >= compare so a corrupted count of 12..15 still reads as last.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       inc,
    output logic [3:0] count,
    output logic       last
);

    // Count register: load has priority over increment, reset over both.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + 4'd1;
        end
    end

    assign last = (count >= ROUND_LAST);

endmodule

// File: rtl/round_ctrl.sv
// Iterative round controller for the ASCON permutation. Sequences 12 (p^a)
// or 6 (p^b) rounds, driving the state-register enable, the initial-state
// select, and the round index/constant. All outputs decode registered state.
// The selected mode is fully captured by the start index loaded into the
// counter, so no separate mode register is kept.
module round_ctrl
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_i,
    output logic       en_reg_o,
    output logic       sel_init_o,
    output logic [3:0] round_o,
    output logic [7:0] const_o,
    output logic       busy_o,
    output logic       done_o
);

    // Both permutations end at the same index; only the start index differs.
    localparam logic [3:0] FIRST_A = 4'(int'(ROUND_LAST) + 1 - ROUNDS_A);
    localparam logic [3:0] FIRST_B = 4'(int'(ROUND_LAST) + 1 - ROUNDS_B);

    type_round_fsm state, state_next;
    logic          first_s, first_next;
    logic          cnt_load;
    logic [3:0]    cnt_value;
    logic          cnt_inc;
    logic [3:0]    round_s;
    logic          round_last;

    round_counter u_round_counter (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load       (cnt_load),
        .load_value (cnt_value),
        .inc        (cnt_inc),
        .count      (round_s),
        .last       (round_last)
    );

    // State and first-round flag registers; reset wins over any start.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state   <= IDLE;
            first_s <= 1'b0;
        end else begin
            state   <= state_next;
            first_s <= first_next;
        end
    end

    // Next-state, counter control and Moore output decode.
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        first_next = first_s;
        cnt_load   = 1'b0;
        cnt_value  = FIRST_A;
        cnt_inc    = 1'b0;
        en_reg_o   = 1'b0;
        sel_init_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    cnt_load   = 1'b1;
                    cnt_value  = mode_i ? FIRST_B : FIRST_A;
                    first_next = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                en_reg_o   = 1'b1;
                busy_o     = 1'b1;
                sel_init_o = first_s;
                first_next = 1'b0;
                if (round_last) begin
                    state_next = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                first_next = 1'b0;
            end
        endcase
    end

    assign round_o = round_s;
    assign const_o = round_const(round_s);

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl. Expected per-cycle outputs are pushed
// to a scoreboard queue ahead of the stimulus; each clock cycle pops one
// entry and compares it with what the DUT shows just after the edge.
module tb_round_ctrl;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic       mode_i  = 1'b0;
    logic       en_reg_o;
    logic       sel_init_o;
    logic [3:0] round_o;
    logic [7:0] const_o;
    logic       busy_o;
    logic       done_o;

    round_ctrl #(
        .ROUNDS_A (12),
        .ROUNDS_B (6)
    ) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .en_reg_o   (en_reg_o),
        .sel_init_o (sel_init_o),
        .round_o    (round_o),
        .const_o    (const_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic       en;
        logic       sel;
        logic [3:0] rnd;
        logic [7:0] cnst;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] ctab [0:11];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic void push(input logic en, input logic sel, input logic [3:0] rnd,
                                 input logic busy, input logic done);
        exp_t e;
        e.en   = en;
        e.sel  = sel;
        e.rnd  = rnd;
        e.cnst = ctab[rnd];
        e.busy = busy;
        e.done = done;
        exp_q.push_back(e);
    endfunction

    function automatic void push_idle(input logic [3:0] rnd);
        push(1'b0, 1'b0, rnd, 1'b0, 1'b0);
    endfunction

    // One permutation: RUN cycles from the mode's first index to 11, then DONE.
    function automatic void push_run(input logic mode, input int upto);
        int first;
        first = mode ? 6 : 0;
        for (int r = first; r <= upto; r++)
            push(1'b1, (r == first), 4'(r), 1'b1, 1'b0);
        if (upto == 11)
            push(1'b0, 1'b0, 4'd11, 1'b0, 1'b1);
    endfunction

    // Drive inputs for one edge, then compare the post-edge outputs.
    task automatic cycle(input logic s, input logic m, input logic r);
        exp_t e;
        @(negedge clock_i);
        start_i = s;
        mode_i  = m;
        reset_i = r;
        @(posedge clock_i);
        #1;
        cyc++;
        check($sformatf("c%0d scoreboard_has_entry", cyc), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("c%0d en_reg", cyc),   32'(en_reg_o),   32'(e.en));
            check($sformatf("c%0d sel_init", cyc), 32'(sel_init_o), 32'(e.sel));
            check($sformatf("c%0d round", cyc),    32'(round_o),    32'(e.rnd));
            check($sformatf("c%0d const", cyc),    32'(const_o),    32'(e.cnst));
            check($sformatf("c%0d busy", cyc),     32'(busy_o),     32'(e.busy));
            check($sformatf("c%0d done", cyc),     32'(done_o),     32'(e.done));
        end
    endtask

    initial begin
        logic run_modes [3];
        ctab = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

        // Reset, then five idle cycles at reset values.
        push_idle(4'd0); cycle(1'b0, 1'b0, 1'b1);
        push_idle(4'd0); cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push_idle(4'd0);
            cycle(1'b0, 1'b0, 1'b0);
        end

        // p^a: 12 rounds; a stray start/mode pulse mid-run must be ignored.
        push_run(1'b0, 11);
        push_idle(4'd11);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++)
            cycle((i == 4), (i == 4), 1'b0);
        push_idle(4'd11); cycle(1'b0, 1'b0, 1'b0);

        // p^b: 6 rounds, 6..11.
        push_run(1'b1, 11);
        push_idle(4'd11);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            cycle(1'b0, 1'b0, 1'b0);

        // start held continuously; mode differs from the accepted one mid-run.
        run_modes = '{1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 3; j++) begin
            int len;
            len = run_modes[j] ? 6 : 12;
            push_run(run_modes[j], 11);
            push_idle(4'd11);
            cycle(1'b1, run_modes[j], 1'b0);
            for (int k = 0; k < len; k++)
                cycle(1'b1, ~run_modes[j], 1'b0);
            cycle((j != 2), ~run_modes[j], 1'b0);
        end

        // Reset at round 5 of p^a: back to IDLE reset values, no done.
        push_run(1'b0, 5);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 1'b0);
        push_idle(4'd0); cycle(1'b0, 1'b0, 1'b1);
        push_idle(4'd0); cycle(1'b0, 1'b0, 1'b0);
        push_idle(4'd0); cycle(1'b0, 1'b0, 1'b0);

        // A following start runs a full 12-round permutation.
        push_run(1'b0, 11);
        push_idle(4'd11);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++)
            cycle(1'b0, 1'b0, 1'b0);

        // Reset and start together: reset wins, controller stays idle.
        push_idle(4'd0); cycle(1'b1, 1'b0, 1'b1);
        push_idle(4'd0); cycle(1'b0, 1'b0, 1'b0);
        push_idle(4'd0); cycle(1'b0, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Iterative round controller for the ASCON permutation datapath. It sits directly upstream of the 320-bit state register and its input multiplexer. Per permutation it sequences 12 rounds (p^a) or 6 rounds (p^b) and drives the following each cycle:
- the register enable;
- the initial-state select;
- the round index and round constant consumed by the constant-addition layer.

A start/done handshake with the top-level mode FSM frames each permutation.

## Interface
Parameters:
- ROUNDS_A, 12, round count of p^a; index runs 0..11
- ROUNDS_B, 6, round count of p^b; index runs 6..11

Ports:
- clock_i  in  1  single clock; all state updates on its rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  request one permutation; sampled only in IDLE
- mode_i  in  1  0 = p^a, 1 = p^b; sampled with start_i
- en_reg_o  out  1  state-register enable, one per computed round
- sel_init_o  out  1  1 = round input comes from the external initial state, 0 = from the register feedback
- round_o  out  4  current round index i
- const_o  out  8  round constant for index i
- busy_o  out  1  high while rounds are in progress
- done_o  out  1  one-cycle pulse after the last round is captured

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - All control outputs are 0; round_o holds its last value.
  - When start_i=1: latch mode_i; load round_s with 0 (p^a) or 6 (p^b); set first_s=1; go to RUN.
- RUN:
  - en_reg_o=1 and busy_o=1.
  - sel_init_o=first_s, so it is 1 only on the first RUN cycle.
  - Each cycle clears first_s.
  - If round_s=11, go to DONE and leave round_s unchanged. Otherwise round_s <= round_s+1.
- DONE: done_o=1, en_reg_o=0, busy_o=0; unconditionally return to IDLE.
- Round constant:
  - const_o = {4'(15-i), 4'(i)}, where i = round_o. This gives 0xF0 for i=0, 0x96 for i=6 and 0x4B for i=11.
  - The constant is combinational from round_s and always valid, including in IDLE.
- Width rule: round_s is 4 bits. Values 12..15 are unreachable. If a corrupted value is reached anyway, the FSM still terminates: any round_s ≥ 11 in RUN goes to DONE.
- Start handling:
  - start_i in RUN or DONE is ignored. It is not queued.
  - A start_i held high across DONE→IDLE launches a new permutation in the IDLE cycle, so there is at least one IDLE cycle between permutations.
- mode_i is ignored except in the cycle start_i is accepted.

## Timing
- Outputs are Moore-style, decoded from registered state. No input→output combinational path exists.
- Start accepted at edge T:
  - RUN cycles are T+1..T+12 for p^a and T+1..T+6 for p^b.
  - done_o is high in cycle T+13 for p^a and T+7 for p^b.
- The register captures round k's result on the edge ending the RUN cycle that carries round_o=k. The final state is therefore valid in the register in the DONE cycle.
- Reset values: state=IDLE, round_s=0, first_s=0, mode=0. Outputs: en_reg_o=0, sel_init_o=0, busy_o=0, done_o=0, round_o=0, const_o=0xF0.
- Reset mid-operation: reset_i has priority over everything. The next cycle is IDLE with reset values, no done_o is produced, and the register contents are left to its own reset.
- Reset and start_i in the same cycle: reset wins and the start is dropped.

## Structure
- ascon_pack gains:
  - enum type_round_fsm {IDLE, RUN, DONE};
  - constants ROUND_FIRST_A=4'd0, ROUND_FIRST_B=4'd6, ROUND_LAST=4'd11;
  - function round_const(i) returning the 8-bit constant, shared with the constant-addition layer.
- One sub-module is natural: round_counter, a 4-bit loadable counter with load value, increment enable and a last-round flag. The FSM instantiates it.

## Test plan
- Reset, then idle for 5 cycles → all outputs at reset values, const_o=0xF0, no en_reg_o.
- start_i=1 with mode_i=0 at T:
  - en_reg_o is high for exactly 12 cycles.
  - round_o steps 0..11.
  - const_o steps F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - sel_init_o is high only at T+1.
  - done_o is high only at T+13.
- start_i=1 with mode_i=1 → 6 rounds, round_o 6..11, const_o 96..4B, done_o at T+7.
- start_i held high continuously with mode_i toggling mid-run:
  - Runs are back-to-back, separated by DONE and one IDLE.
  - Each run uses the mode sampled at its accept.
  - Mid-run pulses have no effect.
- reset_i asserted at round_o=5 of p^a → next cycle in IDLE, outputs at reset values, no done_o. A following start executes a full 12-round run.
- reset_i and start_i high in the same cycle → remains IDLE, no en_reg_o.
